// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared definitions for the pipeline hazard controller:
//   - div_state_e : divider sequencer states (IDLE / BUSY / DONE)
//   - FWD_*       : E-stage operand forward-select encodings
//   - fwd_sel()   : M-over-W forward-select priority for one E-stage source
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // The M stage holds the younger value, so it wins over W. Register 0 is
    // hard-wired to zero and is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       rw_m,
        input logic [4:0] wr_m,
        input logic       rw_w,
        input logic [4:0] wr_w
    );
        if (rw_m && (wr_m != 5'd0) && (wr_m == src))
            return FWD_M;
        else if (rw_w && (wr_w != 5'd0) && (wr_w == src))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/div_seq.sv
// div_seq
//   Multi-cycle divider sequencer. Holds EX for DIV_CYCLES+1 cycles per
//   divide: one IDLE-detect cycle, DIV_CYCLES-1 BUSY cycles, one DONE cycle
//   in which the result is valid and the divide leaves EX.
//   DIV_CYCLES must be within 2..255 (8-bit counter).
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset (FSM -> IDLE, counter -> 0)
//   div_e     in   E-stage instruction is DIV/DIVU
//   div_busy  out  FSM is in BUSY
//   div_done  out  FSM is in DONE (result valid)
//   divstall  out  EX must be held this cycle
module div_seq
    import hazard_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic div_e,
    output logic div_busy,
    output logic div_done,
    output logic divstall
);

    localparam logic [7:0] CNT_LOAD = 8'(DIV_CYCLES - 1);

    div_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_busy = 1'b0;
        div_done = 1'b0;
        divstall = 1'b0;
        case (state_q)
            IDLE: begin
                // The detect cycle already stalls, before BUSY is entered.
                divstall = div_e;
                if (div_e) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                div_busy = 1'b1;
                divstall = 1'b1;
                cnt_d    = cnt_q - 8'd1;
                if (cnt_q == 8'd1)
                    state_d = DONE;
            end
            DONE: begin
                // EX is released here, so div_e still belongs to the finished
                // divide; going straight to IDLE avoids re-triggering on it.
                div_done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard and sequencing controller for the 5-stage MIPS pipeline.
//   Generates forwarding selects, load-use and branch-operand stalls,
//   redirect flushes and the divider hold, and drives the en/clear pins of
//   the F, D, E and M pipeline registers.
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   rs_d, rt_d                  D-stage source registers
//   rs_e, rt_e                  E-stage source registers
//   writereg_e/_m/_w            destination register per stage
//   regwrite_e/_m/_w            stage writes the register file
//   memtoreg_e/_m               stage instruction is a load
//   branch_d, jumpr_d           D-stage compare-branch / jump-register
//   redirect_d                  D-stage taken branch or jump
//   div_e                       E-stage instruction is a divide
//   en_f, en_d, en_e, en_m      register enables
//   clr_d, clr_e, clr_m         synchronous clears (effective with enable)
//   fwd_a_d, fwd_b_d            forward M ALU result to the D comparator
//   fwd_a_e, fwd_b_e            E operand select (00 RF, 01 W, 10 M)
//   div_busy, div_done          divider sequencer status
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [4:0] rs_e,
    input  logic [4:0] rt_e,
    input  logic [4:0] writereg_e,
    input  logic [4:0] writereg_m,
    input  logic [4:0] writereg_w,
    input  logic       regwrite_e,
    input  logic       regwrite_m,
    input  logic       regwrite_w,
    input  logic       memtoreg_e,
    input  logic       memtoreg_m,
    input  logic       branch_d,
    input  logic       jumpr_d,
    input  logic       redirect_d,
    input  logic       div_e,
    output logic       en_f,
    output logic       en_d,
    output logic       en_e,
    output logic       en_m,
    output logic       clr_d,
    output logic       clr_e,
    output logic       clr_m,
    output logic       fwd_a_d,
    output logic       fwd_b_d,
    output logic [1:0] fwd_a_e,
    output logic [1:0] fwd_b_e,
    output logic       div_busy,
    output logic       div_done
);

    logic divstall;
    logic lwstall;
    logic brstall;
    logic hit_e_d;
    logic hit_m_d;
    logic dstall;

    div_seq #(
        .DIV_CYCLES(DIV_CYCLES)
    ) u_div_seq (
        .clk     (clk),
        .reset   (reset),
        .div_e   (div_e),
        .div_busy(div_busy),
        .div_done(div_done),
        .divstall(divstall)
    );

    always_comb begin
        fwd_a_e = fwd_sel(rs_e, regwrite_m, writereg_m, regwrite_w, writereg_w);
        fwd_b_e = fwd_sel(rt_e, regwrite_m, writereg_m, regwrite_w, writereg_w);
        fwd_a_d = regwrite_m && (writereg_m != 5'd0) && (writereg_m == rs_d);
        fwd_b_d = regwrite_m && (writereg_m != 5'd0) && (writereg_m == rt_d);
    end

    always_comb begin
        lwstall = memtoreg_e && (writereg_e != 5'd0) &&
                  ((writereg_e == rs_d) || (writereg_e == rt_d));

        // The D comparator cannot use an operand still being computed in E,
        // nor one a load in M has not yet returned.
        hit_e_d = regwrite_e && (writereg_e != 5'd0) &&
                  ((writereg_e == rs_d) || (writereg_e == rt_d));
        hit_m_d = memtoreg_m && (writereg_m != 5'd0) &&
                  ((writereg_m == rs_d) || (writereg_m == rt_d));
        brstall = (branch_d || jumpr_d) && (hit_e_d || hit_m_d);

        dstall = divstall || lwstall || brstall;
        en_f   = ~dstall;
        en_d   = ~dstall;
        en_e   = ~divstall;
        en_m   = 1'b1;
        clr_m  = divstall;
        // While the divider holds E, its contents must survive, so the
        // load/branch bubble is suppressed.
        clr_e  = (lwstall || brstall) && !divstall;
        // A redirect from a held D is deferred until D is released.
        clr_d  = redirect_d && en_d;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_d, rt_d, rs_e, rt_e;
    logic [4:0] writereg_e, writereg_m, writereg_w;
    logic       regwrite_e, regwrite_m, regwrite_w;
    logic       memtoreg_e, memtoreg_m;
    logic       branch_d, jumpr_d, redirect_d, div_e;
    logic       en_f, en_d, en_e, en_m, clr_d, clr_e, clr_m;
    logic       fwd_a_d, fwd_b_d;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic       div_busy, div_done;

    int n_chk  = 0;
    int n_fail = 0;
    // Reference divider position: -1 = no divide in progress, otherwise
    // the index of the current cycle since the divide was first seen in E.
    int dcyc = -1;

    always #5 clk = ~clk;

    hazard_ctrl #(.DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset),
        .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
        .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m),
        .branch_d(branch_d), .jumpr_d(jumpr_d), .redirect_d(redirect_d), .div_e(div_e),
        .en_f(en_f), .en_d(en_d), .en_e(en_e), .en_m(en_m),
        .clr_d(clr_d), .clr_e(clr_e), .clr_m(clr_m),
        .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .div_busy(div_busy), .div_done(div_done)
    );

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int cur_idx();
        if (dcyc >= 0) return dcyc;
        return div_e ? 0 : -1;
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (regwrite_m && writereg_m != 0 && writereg_m == src) return 2'b10;
        if (regwrite_w && writereg_w != 0 && writereg_w == src) return 2'b01;
        return 2'b00;
    endfunction

    // Full reference comparison of every output against the rules.
    task automatic model_check(input string tag);
        int   idx;
        logic lw, br, ds, bsy, dn, fe;
        idx = cur_idx();
        lw  = memtoreg_e && writereg_e != 0 && (writereg_e == rs_d || writereg_e == rt_d);
        br  = (branch_d || jumpr_d) &&
              ((regwrite_e && writereg_e != 0 && (writereg_e == rs_d || writereg_e == rt_d)) ||
               (memtoreg_m && writereg_m != 0 && (writereg_m == rs_d || writereg_m == rt_d)));
        ds  = (idx >= 0) && (idx < DC);
        bsy = (idx >= 1) && (idx < DC);
        dn  = (idx == DC);
        fe  = !(ds || lw || br);
        chk({tag, ".en_f"},    {1'b0, en_f},    {1'b0, fe});
        chk({tag, ".en_d"},    {1'b0, en_d},    {1'b0, fe});
        chk({tag, ".en_e"},    {1'b0, en_e},    {1'b0, !ds});
        chk({tag, ".en_m"},    {1'b0, en_m},    2'd1);
        chk({tag, ".clr_m"},   {1'b0, clr_m},   {1'b0, ds});
        chk({tag, ".clr_e"},   {1'b0, clr_e},   {1'b0, (lw || br) && !ds});
        chk({tag, ".clr_d"},   {1'b0, clr_d},   {1'b0, redirect_d && fe});
        chk({tag, ".fwd_a_d"}, {1'b0, fwd_a_d}, {1'b0, regwrite_m && writereg_m != 0 && writereg_m == rs_d});
        chk({tag, ".fwd_b_d"}, {1'b0, fwd_b_d}, {1'b0, regwrite_m && writereg_m != 0 && writereg_m == rt_d});
        chk({tag, ".fwd_a_e"}, fwd_a_e, ref_fwd(rs_e));
        chk({tag, ".fwd_b_e"}, fwd_b_e, ref_fwd(rt_e));
        chk({tag, ".busy"},    {1'b0, div_busy}, {1'b0, bsy});
        chk({tag, ".done"},    {1'b0, div_done}, {1'b0, dn});
    endtask

    // Advance one clock; returns at posedge+1 ready for new inputs.
    task automatic tick();
        int idx;
        @(posedge clk);
        idx = cur_idx();
        if (reset)                       dcyc = -1;
        else if (idx >= 0 && idx < DC)   dcyc = idx + 1;
        else                             dcyc = -1;
        #1;
    endtask

    task automatic clear_inputs();
        {rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w} = '0;
        {regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m} = '0;
        {branch_d, jumpr_d, redirect_d, div_e} = '0;
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        clear_inputs();
        #2;
        chk("rst.en_f", {1'b0, en_f}, 2'd1);
        chk("rst.en_e", {1'b0, en_e}, 2'd1);
        chk("rst.clr_d", {1'b0, clr_d}, 2'd0);
        chk("rst.clr_m", {1'b0, clr_m}, 2'd0);
        chk("rst.busy", {1'b0, div_busy}, 2'd0);
        chk("rst.fwd_a_e", fwd_a_e, 2'd0);
        model_check("rst");
        tick();
        tick();
        reset = 1'b0;
        #1;
        model_check("post_rst");

        // Load-use
        memtoreg_e = 1'b1; writereg_e = 5'd8; rs_d = 5'd8;
        #1;
        chk("lu.en_f", {1'b0, en_f}, 2'd0);
        chk("lu.en_d", {1'b0, en_d}, 2'd0);
        chk("lu.clr_e", {1'b0, clr_e}, 2'd1);
        chk("lu.en_e", {1'b0, en_e}, 2'd1);
        model_check("lu");
        tick();
        clear_inputs();
        #1;
        chk("lu_after.clr_e", {1'b0, clr_e}, 2'd0);

        // Load to r0 never stalls
        memtoreg_e = 1'b1; writereg_e = 5'd0; rs_d = 5'd0;
        #1;
        chk("lu_r0.en_d", {1'b0, en_d}, 2'd1);
        tick();
        clear_inputs();

        // Branch operand hazard
        branch_d = 1'b1; regwrite_e = 1'b1; writereg_e = 5'd3; rt_d = 5'd3; redirect_d = 1'b1;
        #1;
        chk("br.en_d", {1'b0, en_d}, 2'd0);
        chk("br.clr_d", {1'b0, clr_d}, 2'd0);
        model_check("br");
        tick();
        clear_inputs();

        // Forward priority
        regwrite_m = 1'b1; writereg_m = 5'd5; regwrite_w = 1'b1; writereg_w = 5'd5; rs_e = 5'd5;
        #1;
        chk("fwd.m_over_w", fwd_a_e, 2'b10);
        model_check("fwd_mw");
        writereg_m = 5'd0;
        #1;
        chk("fwd.w_only", fwd_a_e, 2'b01);
        model_check("fwd_w");
        tick();
        clear_inputs();

        // Divide, then divide with a pending redirect
        for (int pass = 0; pass < 2; pass++) begin
            redirect_d = (pass == 1);
            div_e = 1'b1;
            for (int k = 1; k <= 7; k++) begin
                if (k >= 6) div_e = 1'b0;
                #1;
                chk($sformatf("div%0d.en_e.c%0d", pass, k),  {1'b0, en_e},     {1'b0, k > 4});
                chk($sformatf("div%0d.clr_m.c%0d", pass, k), {1'b0, clr_m},    {1'b0, k <= 4});
                chk($sformatf("div%0d.busy.c%0d", pass, k),  {1'b0, div_busy}, {1'b0, k >= 2 && k <= 4});
                chk($sformatf("div%0d.done.c%0d", pass, k),  {1'b0, div_done}, {1'b0, k == 5});
                if (pass == 1)
                    chk($sformatf("divr.clr_d.c%0d", k), {1'b0, clr_d}, {1'b0, k >= 5});
                model_check($sformatf("div%0d.c%0d", pass, k));
                tick();
            end
            clear_inputs();
        end

        // Reset mid-divide
        div_e = 1'b1;
        tick();            // detect -> BUSY
        tick();            // first BUSY cycle
        #1;
        chk("rmd.busy_before", {1'b0, div_busy}, 2'd1);
        reset = 1'b1;
        dcyc  = -1;
        #1;
        chk("rmd.busy_in_rst", {1'b0, div_busy}, 2'd0);
        model_check("rmd_rst");
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            #1;
            chk($sformatf("rmd.en_e.c%0d", k), {1'b0, en_e},     {1'b0, k == 5});
            chk($sformatf("rmd.done.c%0d", k), {1'b0, div_done}, {1'b0, k == 5});
            model_check($sformatf("rmd.c%0d", k));
            tick();
        end
        clear_inputs();
        tick();

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            rs_d = 5'($urandom_range(0, 3));       rt_d = 5'($urandom_range(0, 3));
            rs_e = 5'($urandom_range(0, 3));       rt_e = 5'($urandom_range(0, 3));
            writereg_e = 5'($urandom_range(0, 3)); writereg_m = 5'($urandom_range(0, 3));
            writereg_w = 5'($urandom_range(0, 3));
            regwrite_e = 1'($urandom);  regwrite_m = 1'($urandom);  regwrite_w = 1'($urandom);
            memtoreg_e = 1'($urandom);  memtoreg_m = 1'($urandom);
            branch_d   = 1'($urandom);  jumpr_d    = ($urandom_range(0, 3) == 0);
            redirect_d = 1'($urandom);  div_e      = ($urandom_range(0, 7) == 0);
            #1;
            model_check($sformatf("rnd%0d", i));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
